// File: rtl/arcade_ctrl_pkg.sv
// Shared types and constants for the arcade control front end:
// coin shaper states, the DIP download index, joystick bit positions and the LED law.
package arcade_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        ARM
    } coin_state_t;

    localparam logic [7:0] DIP_IOCTL_INDEX = 8'd254;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_BTN1  = 4;
    localparam int JOY_COIN1 = 8;

    // Breathing brightness: compare a slow ramp against a fast sawtooth, inverting every half period.
    function automatic logic led_breath(input logic [26:0] c);
        return c[26] ? (c[25:18] > c[7:0]) : (c[25:18] <= c[7:0]);
    endfunction

endpackage

// File: rtl/arcade_ctrl_map_coin_shaper.sv
// One coin channel: turns a raw button rise into a fixed-width pulse followed by
// a guard gap, then waits for the button to be released before accepting another press.
module coin_shaper
    import arcade_ctrl_pkg::*;
#(
    parameter logic [15:0] COIN_PULSE = 16'd4096,
    parameter logic [15:0] COIN_GAP   = 16'd4096
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic coin_raw,
    output logic coin
);

    logic        coin_q;
    logic        coin_prev;
    coin_state_t state;
    logic [15:0] cnt;

    // Rises are only looked for in IDLE, so presses during pulse, gap or arm are dropped.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_q    <= 1'b0;
            coin_prev <= 1'b0;
            state     <= IDLE;
            cnt       <= 16'd0;
            coin      <= 1'b0;
        end else begin
            coin_q    <= coin_raw;
            coin_prev <= coin_q;
            case (state)
                IDLE: begin
                    if (coin_q && !coin_prev) begin
                        state <= PULSE;
                        cnt   <= COIN_PULSE - 16'd1;
                        coin  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == 16'd0) begin
                        state <= GAP;
                        cnt   <= COIN_GAP - 16'd1;
                        coin  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == 16'd0) begin
                        state <= ARM;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ARM: begin
                    if (!coin_q) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    coin  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/arcade_ctrl_map.sv
// Player input and configuration front end between hps_io and a game core:
// DIP capture from the OSD download, frame-synchronous joysticks, coin shaping and activity LED.
module arcade_ctrl_map
    import arcade_ctrl_pkg::*;
#(
    parameter int          NPLAYERS    = 2,
    parameter int          NDIP        = 8,
    parameter int          NCOIN       = 2,
    parameter logic [15:0] COIN_PULSE  = 16'd4096,
    parameter logic [15:0] COIN_GAP    = 16'd4096,
    parameter bit          SYNC_VBL    = 1'b1,
    parameter logic [63:0] DIP_DEFAULT = 64'h0
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [16*NPLAYERS-1:0]  joy_raw,
    input  logic [NCOIN-1:0]        coin_raw,
    input  logic                    vblank,
    input  logic                    ioctl_wr,
    input  logic [7:0]              ioctl_index,
    input  logic [26:0]             ioctl_addr,
    input  logic [15:0]             ioctl_dout,
    output logic [16*NPLAYERS-1:0]  joy,
    output logic [NCOIN-1:0]        coin,
    output logic [8*NDIP-1:0]       dsw,
    output logic                    dip_loaded,
    output logic                    led_user
);

    // DIP state is configuration: it powers up to the default and ignores core reset.
    logic [8*NDIP-1:0] dsw_r     = DIP_DEFAULT[8*NDIP-1:0];
    logic              loaded_r  = 1'b0;
    logic              dip_wr;
    logic              unused_dout;

    assign dip_wr = ioctl_wr
                 && (ioctl_index == DIP_IOCTL_INDEX)
                 && (ioctl_addr[26:3] == 24'd0)
                 && (32'(ioctl_addr[2:0]) < 32'(NDIP));

    assign unused_dout = ^ioctl_dout[15:8];

    always_ff @(posedge clk_sys) begin
        if (dip_wr) begin
            for (int i = 0; i < NDIP; i++) begin
                if (ioctl_addr[2:0] == 3'(i)) begin
                    dsw_r[8*i +: 8] <= ioctl_dout[7:0];
                end
            end
            if (ioctl_addr[2:0] == 3'd0) begin
                loaded_r <= 1'b1;
            end
        end
    end

    assign dsw        = dsw_r;
    assign dip_loaded = loaded_r;

    logic                   vbl_q;
    logic                   vbl_prev;
    logic [16*NPLAYERS-1:0] joy_r;

    // With frame sync the joystick words only move on the registered VBlank rise.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vbl_q    <= 1'b0;
            vbl_prev <= 1'b0;
            joy_r    <= '0;
        end else begin
            vbl_q    <= vblank;
            vbl_prev <= vbl_q;
            if (!SYNC_VBL || (vbl_q && !vbl_prev)) begin
                joy_r <= joy_raw;
            end
        end
    end

    assign joy = joy_r;

    for (genvar g = 0; g < NCOIN; g++) begin : g_coin
        coin_shaper #(
            .COIN_PULSE (COIN_PULSE),
            .COIN_GAP   (COIN_GAP)
        ) u_coin (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .coin_raw (coin_raw[g]),
            .coin     (coin[g])
        );
    end

    logic [26:0] led_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            led_cnt <= 27'd0;
        end else begin
            led_cnt <= led_cnt + 27'd1;
        end
    end

    assign led_user = led_breath(led_cnt);

endmodule

// File: tb/tb_arcade_ctrl_map.sv
// Self-checking bench for arcade_ctrl_map: directed DIP/coin/joystick scenarios followed by
// randomized traffic, all compared every cycle against a timestamp-based reference model.
module tb_arcade_ctrl_map;

    localparam int          NP  = 4;
    localparam int          ND  = 8;
    localparam int          NC  = 2;
    localparam int          CP  = 10;
    localparam int          CG  = 20;
    localparam logic [63:0] DEF = 64'h0123_4567_89AB_CDEF;

    logic                 clk_sys     = 1'b0;
    logic                 reset       = 1'b1;
    logic [16*NP-1:0]     joy_raw     = '0;
    logic [NC-1:0]        coin_raw    = '0;
    logic                 vblank      = 1'b0;
    logic                 ioctl_wr    = 1'b0;
    logic [7:0]           ioctl_index = 8'd0;
    logic [26:0]          ioctl_addr  = 27'd0;
    logic [15:0]          ioctl_dout  = 16'd0;
    logic [16*NP-1:0]     joy;
    logic [NC-1:0]        coin;
    logic [8*ND-1:0]      dsw;
    logic                 dip_loaded;
    logic                 led_user;

    arcade_ctrl_map #(
        .NPLAYERS    (NP),
        .NDIP        (ND),
        .NCOIN       (NC),
        .COIN_PULSE  (16'(CP)),
        .COIN_GAP    (16'(CG)),
        .SYNC_VBL    (1'b1),
        .DIP_DEFAULT (DEF)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .joy_raw     (joy_raw),
        .coin_raw    (coin_raw),
        .vblank      (vblank),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .joy         (joy),
        .coin        (coin),
        .dsw         (dsw),
        .dip_loaded  (dip_loaded),
        .led_user    (led_user)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: DIP bytes, vblank/coin input history, pulse start timestamps and LED count.
    logic [7:0]       m_dsw [ND];
    bit               m_loaded;
    longint           m_led;
    logic [16*NP-1:0] m_joy;
    bit               m_v1, m_v2;
    int               m_cyc = 0;
    int               m_start   [NC];
    bit               m_idle    [NC];
    bit               m_started [NC];
    bit               m_r1      [NC];
    bit               m_r2      [NC];

    int coin0_high  = 0;
    int coin0_rises = 0;
    bit coin0_last  = 1'b0;

    function automatic bit ledExp(input longint c);
        longint top, hi, lo;
        top = (c >> 26) & 1;
        hi  = (c >> 18) & 255;
        lo  = c & 255;
        return (top != 0) ? (hi > lo) : (hi <= lo);
    endfunction

    task automatic modelStep();
        m_cyc++;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < ND) begin
            m_dsw[int'(ioctl_addr)] = ioctl_dout[7:0];
            if (ioctl_addr == 0) m_loaded = 1'b1;
        end
        if (reset) begin
            m_joy = '0;
            m_v1  = 1'b0;
            m_v2  = 1'b0;
            m_led = 0;
            for (int c = 0; c < NC; c++) begin
                m_idle[c]    = 1'b1;
                m_started[c] = 1'b0;
                m_r1[c]      = 1'b0;
                m_r2[c]      = 1'b0;
            end
        end else begin
            if (m_v1 && !m_v2) m_joy = joy_raw;
            m_v2  = m_v1;
            m_v1  = vblank;
            m_led = (m_led + 1) % (longint'(1) << 27);
            for (int c = 0; c < NC; c++) begin
                if (m_idle[c] && m_r1[c] && !m_r2[c]) begin
                    m_idle[c]    = 1'b0;
                    m_started[c] = 1'b1;
                    m_start[c]   = m_cyc;
                end else if (!m_idle[c] && m_cyc >= m_start[c] + CP + CG + 1 && !m_r1[c]) begin
                    m_idle[c] = 1'b1;
                end
                m_r2[c] = m_r1[c];
                m_r1[c] = coin_raw[c];
            end
        end
    endtask

    task automatic applyStimulus(input int n);
        logic [NC-1:0]   exp_coin;
        logic [8*ND-1:0] exp_dsw;
        repeat (n) begin
            @(posedge clk_sys);
            modelStep();
            #1;
            for (int c = 0; c < NC; c++) begin
                exp_coin[c] = m_started[c] && (m_cyc >= m_start[c]) && (m_cyc < m_start[c] + CP);
            end
            for (int i = 0; i < ND; i++) exp_dsw[8*i +: 8] = m_dsw[i];
            checkOutput("joy", joy, m_joy);
            checkOutput("coin", coin, exp_coin);
            checkOutput("dsw", dsw, exp_dsw);
            checkOutput("dip_loaded", dip_loaded, m_loaded);
            checkOutput("led_user", led_user, ledExp(m_led));
            if (coin[0]) coin0_high++;
            if (coin[0] && !coin0_last) coin0_rises++;
            coin0_last = coin[0];
        end
    endtask

    task automatic writeDip(input logic [7:0] idx, input logic [26:0] addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = {8'h5C, data};
        applyStimulus(1);
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        logic [16*NP-1:0] frame_val;

        for (int i = 0; i < ND; i++) m_dsw[i] = DEF[8*i +: 8];
        m_loaded = 1'b0;
        #1;
        checkOutput("dsw_powerup", dsw, DEF);
        checkOutput("loaded_powerup", dip_loaded, 1'b0);

        reset = 1'b1;
        applyStimulus(3);
        checkOutput("led_reset", led_user, 1'b1);
        reset = 1'b0;
        applyStimulus(2);

        // DIP capture, ignored writes, and survival across reset
        writeDip(8'd254, 27'd2, 8'hA5);
        checkOutput("dsw_byte2", dsw[23:16], 8'hA5);
        writeDip(8'd254, 27'd9, 8'h11);
        writeDip(8'd0, 27'd2, 8'h22);
        checkOutput("dsw_byte2_hold", dsw[23:16], 8'hA5);
        reset = 1'b1;
        writeDip(8'd254, 27'd0, 8'h5A);
        applyStimulus(1);
        reset = 1'b0;
        applyStimulus(2);
        checkOutput("dsw_after_reset", dsw[23:16], 8'hA5);
        checkOutput("dsw_byte0_in_reset", dsw[7:0], 8'h5A);
        checkOutput("loaded_set", dip_loaded, 1'b1);

        // Held button: one pulse of exactly CP cycles
        coin0_high = 0;
        coin0_rises = 0;
        coin_raw[0] = 1'b1;
        applyStimulus(100);
        coin_raw[0] = 1'b0;
        applyStimulus(40);
        checkOutput("held_width", 64'(coin0_high), 64'(CP));
        checkOutput("held_pulses", 64'(coin0_rises), 64'd1);

        // Rate limit: a press 15 cycles later is dropped, a later one after release is accepted
        coin0_rises = 0;
        coin_raw[0] = 1'b1;
        applyStimulus(5);
        coin_raw[0] = 1'b0;
        applyStimulus(10);
        coin_raw[0] = 1'b1;
        applyStimulus(5);
        coin_raw[0] = 1'b0;
        applyStimulus(30);
        coin_raw[0] = 1'b1;
        applyStimulus(5);
        coin_raw[0] = 1'b0;
        applyStimulus(40);
        checkOutput("rate_pulses", 64'(coin0_rises), 64'd2);

        // Reset three cycles into a pulse, then a fresh full pulse
        coin_raw[0] = 1'b1;
        applyStimulus(5);
        coin_raw[0] = 1'b0;
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("coin_reset_drop", coin[0], 1'b0);
        reset = 1'b0;
        applyStimulus(3);
        coin0_high = 0;
        coin_raw[0] = 1'b1;
        applyStimulus(15);
        coin_raw[0] = 1'b0;
        applyStimulus(5);
        checkOutput("post_reset_width", 64'(coin0_high), 64'(CP));

        // Frame sync: mid-frame changes are invisible until the VBlank rise
        vblank  = 1'b0;
        joy_raw = 64'h1234_5678_9ABC_DEF0;
        applyStimulus(5);
        joy_raw = 64'h0F0F_F0F0_00FF_FF00;
        applyStimulus(3);
        checkOutput("joy_midframe", joy, 64'h0);
        vblank = 1'b1;
        applyStimulus(1);
        frame_val = 64'h4444_3333_2222_1111;
        joy_raw   = frame_val;
        applyStimulus(1);
        joy_raw = 64'hDEAD_BEEF_CAFE_F00D;
        applyStimulus(3);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("joy_p%0d", p), joy[16*p +: 16], frame_val[16*p +: 16]);
        end
        vblank = 1'b0;
        applyStimulus(5);

        // Randomized traffic on every input
        for (int t = 0; t < 3000; t++) begin
            joy_raw     = {$urandom, $urandom};
            vblank      = ((t % 50) >= 40) ^ ($urandom_range(0, 15) == 0);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 11) == 0) coin_raw[c] = ~coin_raw[c];
            end
            ioctl_wr    = ($urandom_range(0, 3) == 0);
            ioctl_index = ($urandom_range(0, 1) == 0) ? 8'd254 : 8'($urandom);
            ioctl_addr  = ($urandom_range(0, 3) == 0) ? 27'($urandom) : 27'($urandom_range(0, 9));
            ioctl_dout  = 16'($urandom);
            reset       = ($urandom_range(0, 399) == 0);
            applyStimulus(1);
        end
        reset    = 1'b0;
        ioctl_wr = 1'b0;
        coin_raw = '0;
        applyStimulus(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
